job_completion_queue: RTL and testbench

Buffers job-completion records pushed by the job scheduler and writes each one as a 64-bit entry into a host-memory completion ring. It sits directly downstream of the scheduler's completion port (push / ready / 41-bit {pid, jobid}) and upstream of the host write channel. It provides back-pressure, ring-full protection against the host head pointer, a phase bit so software can detect new entries, and drop accounting.

---
 rtl/job_sched_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 49 ++++
 rtl/job_completion_queue.sv | 113 +++++++++++
 tb/tb_job_completion_queue.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/job_sched_pkg.sv
// Shared types for the job scheduler completion path: record/entry layouts and FSM states.
package job_sched_pkg;

  localparam int unsigned REC_W     = 41;
  localparam int unsigned ENTRY_W   = 64;
  localparam int unsigned PID_LSB   = 32;
  localparam int unsigned PHASE_BIT = 63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_e;

  typedef struct packed {
    logic [REC_W-PID_LSB-1:0] pid;
    logic [PID_LSB-1:0]       jobid;
  } rec_t;

  typedef struct packed {
    logic                       phase;
    logic [PHASE_BIT-REC_W-1:0] rsvd;
    rec_t                       rec;
  } entry_t;

  // Build a ring entry: phase in the top bit, reserved bits zero, record at the bottom.
  function automatic entry_t make_entry(input logic phase, input rec_t rec);
    entry_t e;
    e.phase = phase;
    e.rsvd  = '0;
    e.rec   = rec;
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flop storage, occupancy count and full/empty flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/job_completion_queue.sv
// Buffers scheduler completion records and writes them one at a time into a host completion ring.
module job_completion_queue
  import job_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned RING_ENTRIES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              complete_push_i,
  output logic              complete_ready_o,
  input  logic [40:0]       return_data_i,
  input  logic              cfg_enable_i,
  input  logic [63:0]       cfg_ring_base_i,
  input  logic [15:0]       cfg_head_i,
  output logic              wr_req_valid_o,
  input  logic              wr_req_ready_i,
  output logic [63:0]       wr_req_addr_o,
  output logic [63:0]       wr_req_data_o,
  input  logic              wr_rsp_valid_i,
  output logic [15:0]       tail_o,
  output logic              overflow_o,
  output logic [15:0]       drop_cnt_o
);

  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] RING_MASK = 16'(RING_ENTRIES - 1);

  state_e            state;
  logic              init_done;
  logic              phase;
  logic [REC_W-1:0]  fifo_rd_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_ok;
  logic              pop;
  logic              drop;
  logic              ring_full;
  logic [15:0]       tail_inc;

  assign complete_ready_o = init_done & (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push_ok          = complete_push_i & init_done & ~fifo_full;
  assign drop             = complete_push_i & ~complete_ready_o;
  assign tail_inc         = (tail_o + 16'd1) & RING_MASK;
  // One slot stays empty so head == tail always means an empty ring.
  assign ring_full        = (tail_inc == (cfg_head_i & RING_MASK));
  assign pop              = (state == IDLE) & cfg_enable_i & ~fifo_empty & ~ring_full;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_ok),
    .wr_data (return_data_i),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Single outstanding ring write: pop into the request registers, hold until accepted, await ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      init_done      <= 1'b0;
      phase          <= 1'b1;
      wr_req_valid_o <= 1'b0;
      wr_req_addr_o  <= '0;
      wr_req_data_o  <= '0;
      tail_o         <= '0;
      overflow_o     <= 1'b0;
      drop_cnt_o     <= '0;
    end else begin
      init_done <= 1'b1;
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            wr_req_addr_o  <= cfg_ring_base_i + 64'({tail_o, 3'b000});
            wr_req_data_o  <= ENTRY_W'(make_entry(phase, rec_t'(fifo_rd_data)));
            wr_req_valid_o <= 1'b1;
            state          <= REQ;
          end else if (!cfg_enable_i) begin
            tail_o <= '0;
            phase  <= 1'b1;
          end
        end
        REQ: begin
          if (wr_req_ready_i) begin
            wr_req_valid_o <= 1'b0;
            state          <= ACK;
          end
        end
        ACK: begin
          if (wr_rsp_valid_i) begin
            tail_o <= tail_inc;
            if (tail_inc == 16'd0) phase <= ~phase;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_job_completion_queue.sv
// Directed bench for job_completion_queue with a transaction-level ring/FIFO model.
module tb_job_completion_queue;

  localparam int unsigned FD   = 16;
  localparam int unsigned RE   = 4;
  localparam logic [63:0] BASE = 64'h1000_0000;

  logic        clk;
  logic        rst;
  logic        complete_push_i;
  logic        complete_ready_o;
  logic [40:0] return_data_i;
  logic        cfg_enable_i;
  logic [63:0] cfg_ring_base_i;
  logic [15:0] cfg_head_i;
  logic        wr_req_valid_o;
  logic        wr_req_ready_i;
  logic [63:0] wr_req_addr_o;
  logic [63:0] wr_req_data_o;
  logic        wr_rsp_valid_i;
  logic [15:0] tail_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;

  job_completion_queue #(.FIFO_DEPTH(FD), .RING_ENTRIES(RE)) dut (
    .clk              (clk),
    .rst              (rst),
    .complete_push_i  (complete_push_i),
    .complete_ready_o (complete_ready_o),
    .return_data_i    (return_data_i),
    .cfg_enable_i     (cfg_enable_i),
    .cfg_ring_base_i  (cfg_ring_base_i),
    .cfg_head_i       (cfg_head_i),
    .wr_req_valid_o   (wr_req_valid_o),
    .wr_req_ready_i   (wr_req_ready_i),
    .wr_req_addr_o    (wr_req_addr_o),
    .wr_req_data_o    (wr_req_data_o),
    .wr_rsp_valid_i   (wr_rsp_valid_i),
    .tail_o           (tail_o),
    .overflow_o       (overflow_o),
    .drop_cnt_o       (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: records waiting in the FIFO, one outstanding write, ring tail/phase, drop accounting.
  logic [40:0] mq[$];
  logic [63:0] w_addr[$];
  logic [63:0] w_data[$];
  bit          m_init, m_phase, m_req, m_ack, m_ovf, m_rdy;
  int unsigned m_tail, m_drops;
  logic [63:0] m_addr, m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_init = 0; m_phase = 1; m_req = 0; m_ack = 0; m_ovf = 0;
      m_tail = 0; m_drops = 0;
    end else begin
      m_rdy = m_init && (mq.size() < FD);
      if (m_req) begin
        if (wr_req_ready_i) begin
          m_req = 0; m_ack = 1;
          w_addr.push_back(m_addr);
          w_data.push_back(m_data);
        end
      end else if (m_ack) begin
        if (wr_rsp_valid_i) begin
          m_ack  = 0;
          m_tail = (m_tail + 1) % RE;
          if (m_tail == 0) m_phase = !m_phase;
        end
      end else if (!cfg_enable_i) begin
        m_tail = 0; m_phase = 1;
      end else if (mq.size() != 0 && ((m_tail + 1) % RE) != (int'(cfg_head_i) % RE)) begin
        m_data = {m_phase, 22'b0, mq.pop_front()};
        m_addr = cfg_ring_base_i + 64'(m_tail) * 64'd8;
        m_req  = 1;
      end
      if (complete_push_i) begin
        if (m_rdy) mq.push_back(return_data_i);
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
      m_init = 1;
    end
  end

  // Every-cycle compare of all outputs against the model, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("ready", 64'(complete_ready_o), 64'(m_init && (mq.size() < FD)));
      chk("valid", 64'(wr_req_valid_o), 64'(m_req));
      if (m_req) begin
        chk("addr", wr_req_addr_o, m_addr);
        chk("data", wr_req_data_o, m_data);
      end
      chk("tail", 64'(tail_o), 64'(m_tail));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drops));
    end
  end

  bit ack_auto, head_auto, spur;
  logic [15:0] head_val;

  task automatic step(input bit push, input logic [40:0] rec);
    @(negedge clk);
    complete_push_i = push;
    return_data_i   = rec;
    wr_rsp_valid_i  = ack_auto ? m_ack : spur;
    cfg_head_i      = head_auto ? 16'(m_tail) : head_val;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 41'd0);
  endtask

  int unsigned n0;
  logic [63:0] d;
  int unsigned offs [5] = '{0, 8, 16, 24, 0};
  bit          phs  [5] = '{1, 1, 1, 1, 0};

  initial begin
    rst = 1'b1;
    complete_push_i = 1'b0; return_data_i = '0;
    cfg_enable_i = 1'b1; cfg_ring_base_i = BASE; cfg_head_i = '0;
    wr_req_ready_i = 1'b0; wr_rsp_valid_i = 1'b0;
    ack_auto = 1; head_auto = 0; spur = 0; head_val = 16'd0;

    // Reset values
    idle(2);
    chk("rst_ready", 64'(complete_ready_o), 64'd0);
    chk("rst_valid", 64'(wr_req_valid_o), 64'd0);
    chk("rst_addr", wr_req_addr_o, 64'd0);
    chk("rst_data", wr_req_data_o, 64'd0);
    chk("rst_tail", 64'(tail_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    rst = 1'b0;
    idle(1);

    // Basic path
    wr_req_ready_i = 1'b1;
    n0 = w_addr.size();
    step(1'b1, {9'h05, 32'hDEAD_BEEF});
    idle(6);
    chk("basic_nwr", 64'(w_addr.size() - n0), 64'd1);
    if (w_addr.size() > n0) begin
      chk("basic_addr", w_addr[n0], 64'h1000_0000);
      chk("basic_data", w_data[n0], 64'h8000_0005_DEAD_BEEF);
    end
    chk("basic_tail", 64'(tail_o), 64'd1);

    // Wrap and phase: host keeps head equal to tail after each ack
    cfg_enable_i = 1'b0; idle(1); cfg_enable_i = 1'b1;
    head_auto = 1;
    n0 = w_addr.size();
    for (int i = 0; i < 5; i++) step(1'b1, {9'(i + 1), 32'hA000_0000 + 32'(i)});
    idle(25);
    chk("wrap_nwr", 64'(w_addr.size() - n0), 64'd5);
    if (w_addr.size() >= n0 + 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("wrap_addr", w_addr[n0 + i], BASE + 64'(offs[i]));
        d = w_data[n0 + i];
        chk("wrap_phase", 64'(d[63]), 64'(phs[i]));
      end
    end
    chk("wrap_tail", 64'(tail_o), 64'd1);

    // Ring full: head fixed at 0 stalls the 4th record
    head_auto = 0; head_val = 16'd0;
    cfg_enable_i = 1'b0; idle(1); cfg_enable_i = 1'b1;
    n0 = w_addr.size();
    for (int i = 0; i < 4; i++) step(1'b1, {9'h0B, 32'hB000_0000 + 32'(i)});
    idle(20);
    chk("full_nwr", 64'(w_addr.size() - n0), 64'd3);
    chk("full_tail", 64'(tail_o), 64'd3);
    chk("full_valid", 64'(wr_req_valid_o), 64'd0);
    head_val = 16'd1;
    idle(10);
    chk("full_nwr2", 64'(w_addr.size() - n0), 64'd4);
    if (w_addr.size() >= n0 + 4) chk("full_addr4", w_addr[n0 + 3], BASE + 64'h18);
    chk("full_tail2", 64'(tail_o), 64'd0);

    // Overflow: host stalls, 20 pushes back to back
    cfg_enable_i = 1'b0; idle(1); cfg_enable_i = 1'b1;
    head_auto = 1;
    wr_req_ready_i = 1'b0;
    n0 = w_addr.size();
    for (int i = 1; i <= 20; i++) step(1'b1, {9'(i), 32'hC000_0000 + 32'(i)});
    idle(3);
    chk("ovf_flag", 64'(overflow_o), 64'd1);
    chk("ovf_drops", 64'(drop_cnt_o), 64'd3);
    chk("ovf_ready", 64'(complete_ready_o), 64'd0);
    chk("ovf_valid", 64'(wr_req_valid_o), 64'd1);
    wr_req_ready_i = 1'b1;
    idle(80);
    chk("ovf_nwr", 64'(w_addr.size() - n0), 64'd17);
    if (w_data.size() > 0) begin
      d = w_data[w_data.size() - 1];
      chk("ovf_last", d, 64'h8000_0011_C000_0011);
    end
    chk("ovf_tail", 64'(tail_o), 64'd1);

    // Back-pressure stability with spurious acks during REQ
    wr_req_ready_i = 1'b0; ack_auto = 0; spur = 1'b0;
    step(1'b1, {9'h1A, 32'h5555_AAAA});
    idle(1);
    spur = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 41'd0);
      chk("bp_valid", 64'(wr_req_valid_o), 64'd1);
      chk("bp_addr", wr_req_addr_o, BASE + 64'h8);
      chk("bp_data", wr_req_data_o, 64'h8000_001A_5555_AAAA);
      chk("bp_tail", 64'(tail_o), 64'd1);
    end
    spur = 1'b0; ack_auto = 1; wr_req_ready_i = 1'b1;
    idle(4);
    chk("bp_tail2", 64'(tail_o), 64'd2);

    // Reset while waiting for the ack
    ack_auto = 0; spur = 1'b0;
    step(1'b1, {9'h07, 32'h0000_1234});
    idle(2);
    step(1'b0, 41'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(wr_req_valid_o), 64'd0);
    chk("arst_tail", 64'(tail_o), 64'd0);
    chk("arst_drop", 64'(drop_cnt_o), 64'd0);
    chk("arst_ovf", 64'(overflow_o), 64'd0);
    chk("arst_ready", 64'(complete_ready_o), 64'd0);
    step(1'b0, 41'd0);
    rst = 1'b0;
    ack_auto = 1;
    #1 chk("arst_ready_lo", 64'(complete_ready_o), 64'd0);
    step(1'b0, 41'd0);
    chk("arst_ready_hi", 64'(complete_ready_o), 64'd1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
